// File: rtl/sq_pkg.sv
// Package sq_pkg
//   Definitions shared by the sequential squarer and the digit-by-digit
//   square-root unit:
//   - sq_state_e : FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
//   - SQ_WIDTH   : default root width in bits
package sq_pkg;

  localparam int SQ_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sq_state_e;

endpackage : sq_pkg

// File: rtl/sq_root_check.sv
// Module sq_root_check
//   Combinational bracket compare. It confirms that m is the floor square
//   root of target, given sq = m*m:
//     ok = (sq <= target) && (target < sq + 2*m + 1)
//   The upper bound is (m+1)^2. It is formed at 2*WIDTH+1 bits, so the
//   largest m does not wrap.
// Ports
//   sq     in  2*WIDTH  square of the candidate root
//   m      in  WIDTH    candidate root
//   target in  2*WIDTH  value whose floor-sqrt is claimed to be m
//   ok     out 1        1 when m == floor(sqrt(target))
module sq_root_check
  import sq_pkg::*;
#(
  parameter int WIDTH = SQ_WIDTH
) (
  input  logic [2*WIDTH-1:0] sq,
  input  logic [WIDTH-1:0]   m,
  input  logic [2*WIDTH-1:0] target,
  output logic               ok
);

  logic [2*WIDTH:0] upper;

  assign upper = {1'b0, sq} + {{WIDTH{1'b0}}, m, 1'b0} + (2*WIDTH+1)'(1);
  assign ok    = (sq <= target) && ({1'b0, target} < upper);

endmodule : sq_root_check

// File: rtl/int_square_seq.sv
// Module int_square_seq
//   Sequential unsigned squarer that uses shift-add. It processes one
//   multiplier bit per cycle over WIDTH cycles. The design is the inverse of
//   the square-root unit, so a root can be squared back for round-trip checks.
//
//   Optional feature (macro SQUARE_ROOT_CHECK_EN): target_in is captured
//   together with the root. root_ok reports whether root_in is
//   floor(sqrt(target_in)). The flag is updated and held together with square.
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   start      in   1        request, sampled only in IDLE
//   root_in    in   WIDTH    operand, captured on the accepting edge
//   target_in  in   2*WIDTH  (macro only) value to bracket-check against
//   busy       out  1        high in RUN and DONE
//   done       out  1        one-cycle pulse, square just became valid
//   square     out  2*WIDTH  root_in^2, held until the next result
//   root_ok    out  1        (macro only) check flag, valid with done
module int_square_seq
  import sq_pkg::*;
#(
  parameter int WIDTH = SQ_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     root_in,
`ifdef SQUARE_ROOT_CHECK_EN
  input  logic [2*WIDTH-1:0]   target_in,
  output logic                 root_ok,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   square
);

  localparam int CW = $clog2(WIDTH) + 1;

  sq_state_e          state_q, state_d;
  logic [WIDTH-1:0]   m_q;        // multiplicand, constant during an operation
  logic [WIDTH-1:0]   q_q;        // multiplier, shifted right one bit per RUN edge
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt_q;      // bit index of q_q[0]; never wraps inside an operation
  logic               last_bit;

  // The partial product of bit cnt_q is m shifted into place. The sum of all
  // partial products is at most (2^WIDTH-1)^2, so 2*WIDTH bits never overflow.
  assign acc_next = q_q[0] ? acc_q + ({{WIDTH{1'b0}}, m_q} << cnt_q) : acc_q;

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments. All registers then
  // see the pre-edge values of each other, just as the flops do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef SQUARE_ROOT_CHECK_EN
  logic [2*WIDTH-1:0] target_q;
  logic               check_ok;

  // The check uses the completed square, so it sees acc_next on the last edge.
  sq_root_check #(.WIDTH(WIDTH)) u_check (
    .sq     (acc_next),
    .m      (m_q),
    .target (target_q),
    .ok     (check_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      root_ok  <= 1'b0;
    end else begin
      if (state_q == IDLE && start) target_q <= target_in;
      if (last_bit)                 root_ok  <= check_ok;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      q_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      square <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          m_q   <= root_in;
          q_q   <= root_in;
          acc_q <= '0;
          cnt_q <= '0;
        end
        RUN: begin
          acc_q <= acc_next;
          q_q   <= q_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) square <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule : int_square_seq

// File: tb/tb_int_square_seq.sv
// Testbench tb_int_square_seq
//   Directed self-checking bench for int_square_seq with WIDTH=8. The same
//   file also covers the SQUARE_ROOT_CHECK_EN build. Outputs are sampled 1 ns
//   after the rising edge, and inputs are changed at that same point.
module tb_int_square_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  root_in;
  logic        busy;
  logic        done;
  logic [15:0] square;
`ifdef SQUARE_ROOT_CHECK_EN
  logic [15:0] target_in;
  logic        root_ok;
`endif

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int n_done;

  int_square_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .root_in   (root_in),
`ifdef SQUARE_ROOT_CHECK_EN
    .target_in (target_in),
    .root_ok   (root_ok),
`endif
    .busy      (busy),
    .done      (done),
    .square    (square)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen. The count is bounded, so a dead DUT
  // shows up as a wrong latency rather than a hang.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  // Pulses start for a single edge, scrambles root_in after the accept edge,
  // and waits for done.
  task automatic run_op(input logic [7:0] r, input logic [15:0] t, output int cycles);
    start   = 1'b1;
    root_in = r;
`ifdef SQUARE_ROOT_CHECK_EN
    target_in = t;
`else
    if (t != 16'd0) ;
`endif
    tick();
    start   = 1'b0;
    root_in = 8'($urandom);
`ifdef SQUARE_ROOT_CHECK_EN
    target_in = 16'($urandom);
`endif
    wait_done(cycles);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    root_in = 8'd0;
`ifdef SQUARE_ROOT_CHECK_EN
    target_in = 16'd0;
`endif
    #2;
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_square", 32'(square), 32'd0);
`ifdef SQUARE_ROOT_CHECK_EN
    check("reset_root_ok", 32'(root_ok), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: 16^2. done appears WIDTH edges after the accept edge (WIDTH+1 including it).
    run_op(8'd16, 16'd0, lat);
    check("t1_latency", 32'(lat),    32'd8);
    check("t1_square",  32'(square), 32'd256);
    tick();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_square_held", 32'(square), 32'd256);

    // 2: root 0, then 255, with start held high throughout.
    start   = 1'b1;
    root_in = 8'd0;
    tick();
    check("t2_busy_run", 32'(busy), 32'd1);
    wait_done(lat);
    check("t2_latency0", 32'(lat),    32'd8);
    check("t2_square0",  32'(square), 32'd0);
    root_in = 8'd255;
    tick();  // DONE -> IDLE; start is not sampled in DONE
    check("t2_idle_gap", 32'(busy), 32'd0);
    tick();  // accept edge for 255
    start   = 1'b0;
    root_in = 8'd1;
    wait_done(lat);
    check("t2_latency255", 32'(lat),    32'd8);
    check("t2_square255",  32'(square), 32'hFE01);
    tick();

    // 3: a start pulse during RUN is ignored. Exactly one done is seen, and
    //    no second operation follows it.
    start   = 1'b1;
    root_in = 8'd7;
    tick();
    start   = 1'b0;
    tick();
    tick();
    start   = 1'b1;
    root_in = 8'd3;
    tick();
    start   = 1'b0;
    lat     = 0;
    wait_done(lat);
    check("t3_latency", 32'(lat + 3), 32'd8);
    check("t3_square",  32'(square),  32'd49);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("t3_extra_done", 32'(n_done), 32'd0);
    check("t3_square_held", 32'(square), 32'd49);

    // 4: reset asserted in RUN cycle 4 of 200 aborts the operation; a rerun gives 40000.
    start   = 1'b1;
    root_in = 8'd200;
    tick();
    start   = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t4_abort_busy",   32'(busy),   32'd0);
    check("t4_abort_done",   32'(done),   32'd0);
    check("t4_abort_square", 32'(square), 32'd0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("t4_no_done", 32'(n_done), 32'd0);
    run_op(8'd200, 16'd0, lat);
    check("t4_rerun_latency", 32'(lat),    32'd8);
    check("t4_rerun_square",  32'(square), 32'd40000);
    tick();

`ifdef SQUARE_ROOT_CHECK_EN
    // 5: floor-sqrt bracket check, including the widest root.
    run_op(8'd14, 16'd200, lat);
    check("t5_14_200", 32'(root_ok), 32'd1);
    tick();
    run_op(8'd15, 16'd200, lat);
    check("t5_15_200", 32'(root_ok), 32'd0);
    tick();
    run_op(8'd255, 16'd65535, lat);
    check("t5_255_65535", 32'(root_ok), 32'd1);
    tick();
    check("t5_held", 32'(root_ok), 32'd1);
    run_op(8'd254, 16'd65025, lat);
    check("t5_254_65025", 32'(root_ok), 32'd0);
    tick();
`endif

    // 6: sweep all roots in shuffled order against r*r, one done per start.
    begin
      logic [7:0] order [256];
      for (int i = 0; i < 256; i++) order[i] = 8'(i);
      for (int i = 255; i > 0; i--) begin
        int j;
        logic [7:0] tmp;
        j        = int'($urandom_range(i, 0));
        tmp      = order[i];
        order[i] = order[j];
        order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
        run_op(order[i], 16'd0, lat);
        check($sformatf("sweep_lat_%0d", order[i]), 32'(lat), 32'd8);
        check($sformatf("sweep_sq_%0d", order[i]), 32'(square),
              32'(order[i]) * 32'(order[i]));
        tick();
        check($sformatf("sweep_pulse_%0d", order[i]), 32'(done), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_int_square_seq
